// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: divider FSM states, divide aluops and default width.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} div_state_t;

  localparam logic [7:0] ALUOP_DIV  = 8'b00011010;
  localparam logic [7:0] ALUOP_DIVU = 8'b00011011;
  localparam int         DIV_WIDTH  = 32;
endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  // The full remainder is kept in the shift so that divisors above 2^(WIDTH-1)
  // still divide exactly; the partial remainder needs WIDTH+1 bits.
  logic [WIDTH:0] p;

  assign p        = {rem, dvd_msb};
  assign q_bit    = (p >= {1'b0, dvs});
  assign rem_next = q_bit ? WIDTH'(p - {1'b0, dvs}) : p[WIDTH-1:0];
endmodule

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per cycle, flushable.
module ex_div
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, q;
  logic             q_neg, r_neg;

  logic [WIDTH-1:0] rem_next, q_fin;
  logic             q_bit;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  ex_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_fin = {q[WIDTH-2:0], q_bit};
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor  : divisor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready        <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      cnt          <= '0;
      rem          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      q            <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        ready <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              // Work on magnitudes; signs are re-applied on the final step.
              dvd   <= a_abs;
              dvs   <= b_abs;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              rem   <= '0;
              q     <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
              state <= (divisor == '0) ? DZERO : BUSY;
              ready <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
          BUSY: begin
            rem <= rem_next;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            q   <= q_fin;
            if (cnt == '0) begin
              quotient     <= q_neg ? -q_fin : q_fin;
              remainder    <= r_neg ? -rem_next : rem_next;
              div_by_zero  <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
              ready        <= 1'b1;
              busy         <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DZERO: begin
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b1;
            result_valid <= 1'b1;
            state        <= DONE;
            ready        <= 1'b1;
            busy         <= 1'b0;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ex_div.sv
// Directed and random checks of ex_div against a plain-arithmetic division model.
module tb_ex_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         cancel = 1'b0;
  logic         ready, busy, result_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q, exp_r, last_q, last_r;
  logic         exp_dz, last_dz;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: SV integer division truncates toward zero, matching DIV/DIVU.
  function automatic void model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa, sb;
    if (b == 0) begin
      q = '0; r = '0; dz = 1'b1;
    end else if (sop) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Called #1 after an edge; start is seen at the following edge.
  task automatic issue(input string tag, input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
    model(sop, a, b, exp_q, exp_r, exp_dz);
    start = 1'b1; signed_op = sop; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rdy"}, ready, 0);
  endtask

  task automatic wait_result(input string tag, input int poke_at, input bit pulse_chk);
    int cyc = 0;
    bit got = 0;
    while (cyc < 100 && !got) begin
      @(posedge clk); cyc++; #1;
      if (cyc == poke_at) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9);
      end else start = 1'b0;
      if (result_valid) got = 1;
    end
    start = 1'b0;
    chk({tag, "_lat"}, cyc, exp_dz ? 1 : W);
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_r"}, remainder, exp_r);
    chk({tag, "_dz"}, div_by_zero, exp_dz);
    last_q = exp_q; last_r = exp_r; last_dz = exp_dz;
    if (pulse_chk) begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, result_valid, 0);
    end
  endtask

  task automatic check_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen++;
    end
    chk({tag, "_norv"}, seen, 0);
    chk({tag, "_q"}, quotient, last_q);
    chk({tag, "_r"}, remainder, last_r);
    chk({tag, "_dz"}, div_by_zero, last_dz);
  endtask

  initial begin
    #12;
    chk("rst_rdy", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue("u100_7", 0, 100, 7);                 wait_result("u100_7", 0, 1);
    issue("sm7_2", 1, -32'sd7, 2);              wait_result("sm7_2", 0, 1);
    issue("s7_m2", 1, 7, -32'sd2);              wait_result("s7_m2", 0, 1);
    issue("umax_1", 0, 32'hFFFF_FFFF, 1);       wait_result("umax_1", 0, 1);
    issue("sovf", 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("sovf", 0, 1);
    issue("ubig", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_result("ubig", 0, 1);
    issue("dz_u", 0, 1234, 0);                  wait_result("dz_u", 0, 1);
    issue("dz_s", 1, -32'sd5, 0);               wait_result("dz_s", 0, 1);
    issue("u9_3", 0, 9, 3);                     wait_result("u9_3", 0, 1);

    // Flush mid-operation: nothing produced, previous result retained.
    issue("can", 0, 50, 5);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    chk("can_rdy", ready, 1);
    chk("can_busy", busy, 0);
    check_quiet("can", 40);

    // start together with cancel is dropped.
    start = 1'b1; cancel = 1'b1; dividend = 77; divisor = 7;
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
    chk("sc_rdy", ready, 1);
    chk("sc_busy", busy, 0);
    check_quiet("sc", 40);

    // Back-to-back: second start lands in the DONE cycle, with a stray mid-BUSY start.
    issue("b2b1", 0, 20, 3);                    wait_result("b2b1", 0, 0);
    issue("b2b2", 0, 21, 4);                    wait_result("b2b2", 5, 1);

    // Asynchronous reset in the middle of an operation.
    issue("rmid", 0, 1000, 3);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rmid_q", quotient, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_rdy", ready, 1);
    chk("rmid_rv", result_valid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    check_quiet("rmid", 40);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic         s;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 20);
        2: b = (i % 8 == 2) ? 0 : -$urandom_range(1, 20);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      s = $urandom_range(0, 1);
      issue($sformatf("rnd%0d", i), s, a, b);
      wait_result($sformatf("rnd%0d", i), 0, (i % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
